waveform_lut_dds_mc: RTL and testbench



---
 rtl/waveform_lut_dds_pkg.sv | 30 +++
 rtl/waveform_lut_dds_mc_ram.sv | 37 +++
 rtl/waveform_lut_dds_mc.sv | 202 ++++++++++++++++++++
 tb/tb_waveform_lut_dds_mc.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/waveform_lut_dds_pkg.sv
// ---------------------------------------------------------------------------
// waveform_lut_dds_pkg
//   Shared types and width helpers for the multi-channel waveform DDS.
//   - dds_state_t : sequencer states (IDLE, RUN, LAST, PUBLISH)
//   - addr_width  : waveform RAM address width for a given depth
//   - phase_width : full accumulator width (address bits + fractional bits)
//   - idx_width   : channel index counter width (at least one bit)
// ---------------------------------------------------------------------------
package waveform_lut_dds_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        LAST    = 2'd2,
        PUBLISH = 2'd3
    } dds_state_t;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int phase_width(input int depth, input int frac_bits);
        return addr_width(depth) + frac_bits;
    endfunction

    function automatic int idx_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/waveform_lut_dds_mc_ram.sv
// ---------------------------------------------------------------------------
// waveform_ram_1r1w
//   Single-clock RAM, one write port and one registered read port. A read
//   and a write to the same address in the same cycle return the old word,
//   which is the natural block-RAM behaviour.
//   Ports:
//     CLK_SYS  : clock
//     WR_EN    : write strobe
//     WR_ADDR  : write address
//     WR_DATA  : write data
//     RD_ADDR  : read address (data returned on the following cycle)
//     RD_DATA  : registered read data
//   Contents are not reset.
// ---------------------------------------------------------------------------
module waveform_ram_1r1w #(
    parameter int  DATA_W = 12,
    parameter int  DEPTH  = 256,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                     CLK_SYS,
    input  logic                     WR_EN,
    input  logic [AW-1:0]            WR_ADDR,
    input  logic signed [DATA_W-1:0] WR_DATA,
    input  logic [AW-1:0]            RD_ADDR,
    output logic signed [DATA_W-1:0] RD_DATA
);

    logic signed [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK_SYS) begin
        if (WR_EN) begin
            mem[WR_ADDR] <= WR_DATA;
        end
        RD_DATA <= mem[RD_ADDR];
    end

endmodule

// File: rtl/waveform_lut_dds_mc.sv
// ---------------------------------------------------------------------------
// waveform_lut_dds_mc
//   Multi-channel phase-accumulator waveform generator. One shared waveform
//   RAM is time-multiplexed over NUM_CH channels: each sample trigger walks
//   the channels one per cycle, advances each accumulator, reads the RAM at
//   the integer part of the phase and publishes the whole sample vector at
//   once.
//   Ports:
//     CLK_SYS, nRST : clock, asynchronous active-low reset
//     SMP_TRGG      : one-cycle sample trigger
//     CH_EN         : per-channel enable (low also rearms one-shot)
//     CH_ONESHOT    : per-channel one-shot (1) / continuous (0)
//     CH_STEP       : per-channel phase increment, PHASE_W bits each
//     WR_EN/ADDR/DATA : waveform RAM write port
//     CLR_OVR       : clears OVERRUN
//     LUT_VALUE     : published sample vector, BIT_WIDTH bits per channel
//     VALID         : one-cycle pulse when LUT_VALUE/LUT_END update
//     LUT_END       : per-channel wrap flag for the published sample
//     BUSY          : sequencer not idle
//     OVERRUN       : sticky, a trigger arrived while busy
// ---------------------------------------------------------------------------
module waveform_lut_dds_mc
    import waveform_lut_dds_pkg::*;
#(
    parameter int  NUM_CH     = 4,
    parameter int  BIT_WIDTH  = 12,
    parameter int  LUT_DEPTH  = 256,
    parameter int  FRAC_WIDTH = 8,
    localparam int ADDR_W     = addr_width(LUT_DEPTH),
    localparam int PHASE_W    = phase_width(LUT_DEPTH, FRAC_WIDTH)
) (
    input  logic                          CLK_SYS,
    input  logic                          nRST,
    input  logic                          SMP_TRGG,
    input  logic [NUM_CH-1:0]             CH_EN,
    input  logic [NUM_CH-1:0]             CH_ONESHOT,
    input  logic [NUM_CH*PHASE_W-1:0]     CH_STEP,
    input  logic                          WR_EN,
    input  logic [ADDR_W-1:0]             WR_ADDR,
    input  logic [BIT_WIDTH-1:0]          WR_DATA,
    input  logic                          CLR_OVR,
    output logic [NUM_CH*BIT_WIDTH-1:0]   LUT_VALUE,
    output logic                          VALID,
    output logic [NUM_CH-1:0]             LUT_END,
    output logic                          BUSY,
    output logic                          OVERRUN
);

    localparam int CH_W = idx_width(NUM_CH);

    dds_state_t state;

    logic [CH_W-1:0]              ch_idx_p0;
    logic                         run_p0;
    logic [PHASE_W-1:0]           phase_cur_p0;
    logic [PHASE_W-1:0]           step_p0;
    logic [PHASE_W:0]             sum_p0;
    logic [ADDR_W-1:0]            rd_addr_p0;

    logic                         vld_p1;
    logic [CH_W-1:0]              ch_idx_p1;
    logic                         zero_p1;
    logic signed [BIT_WIDTH-1:0]  rd_data_p1;

    logic [PHASE_W-1:0]           phase [NUM_CH];
    logic [NUM_CH-1:0]            done;
    logic signed [BIT_WIDTH-1:0]  shadow_val [NUM_CH];
    logic signed [BIT_WIDTH-1:0]  shadow_nxt [NUM_CH];
    logic [NUM_CH-1:0]            shadow_end;

    // ---- stage p0: channel slot, accumulator update, RAM address ----------
    always_comb begin
        run_p0       = (state == RUN);
        phase_cur_p0 = phase[ch_idx_p0];
        step_p0      = CH_STEP[int'(ch_idx_p0)*PHASE_W +: PHASE_W];
        sum_p0       = {1'b0, phase_cur_p0} + {1'b0, step_p0};
        rd_addr_p0   = phase_cur_p0[PHASE_W-1:FRAC_WIDTH];
    end

    waveform_ram_1r1w #(
        .DATA_W (BIT_WIDTH),
        .DEPTH  (LUT_DEPTH)
    ) u_ram (
        .CLK_SYS (CLK_SYS),
        .WR_EN   (WR_EN),
        .WR_ADDR (WR_ADDR),
        .WR_DATA (WR_DATA),
        .RD_ADDR (rd_addr_p0),
        .RD_DATA (rd_data_p1)
    );

    // ---- stage p1: RAM data returns, captured into the channel's shadow ----
    // The last channel's word arrives during LAST, the same cycle the output
    // vector is loaded, so the output load takes the shadow vector with this
    // capture already applied.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            shadow_nxt[k] = shadow_val[k];
            if (vld_p1 && (ch_idx_p1 == CH_W'(k))) begin
                shadow_nxt[k] = zero_p1 ? '0 : rd_data_p1;
            end
        end
    end

    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < NUM_CH; k++) begin
                phase[k]      <= '0;
                shadow_val[k] <= '0;
            end
            done       <= '0;
            shadow_end <= '0;
            vld_p1     <= 1'b0;
            ch_idx_p1  <= '0;
            zero_p1    <= 1'b0;
        end else begin
            vld_p1    <= run_p0;
            ch_idx_p1 <= ch_idx_p0;
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_val[k] <= shadow_nxt[k];
            end
            if (run_p0) begin
                if (!CH_EN[ch_idx_p0]) begin
                    // Disabled: park the channel and rearm one-shot.
                    phase[ch_idx_p0]      <= '0;
                    done[ch_idx_p0]       <= 1'b0;
                    shadow_end[ch_idx_p0] <= 1'b0;
                    zero_p1               <= 1'b1;
                end else if (done[ch_idx_p0]) begin
                    phase[ch_idx_p0]      <= '0;
                    shadow_end[ch_idx_p0] <= 1'b0;
                    zero_p1               <= 1'b1;
                end else begin
                    shadow_end[ch_idx_p0] <= sum_p0[PHASE_W];
                    zero_p1               <= 1'b0;
                    if (CH_ONESHOT[ch_idx_p0] && sum_p0[PHASE_W]) begin
                        // Wrap sample is still published; silence from next pass.
                        done[ch_idx_p0]  <= 1'b1;
                        phase[ch_idx_p0] <= '0;
                    end else begin
                        phase[ch_idx_p0] <= sum_p0[PHASE_W-1:0];
                    end
                end
            end
        end
    end

    // ---- sequencer and registered outputs ----------------------------------
    // The output vector is loaded on the LAST->PUBLISH edge so that VALID and
    // the new LUT_VALUE are both visible throughout the PUBLISH cycle.
    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            ch_idx_p0 <= '0;
            BUSY      <= 1'b0;
            VALID     <= 1'b0;
            OVERRUN   <= 1'b0;
            LUT_VALUE <= '0;
            LUT_END   <= '0;
        end else begin
            VALID <= 1'b0;
            if (SMP_TRGG && BUSY) begin
                OVERRUN <= 1'b1;
            end else if (CLR_OVR) begin
                OVERRUN <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (SMP_TRGG) begin
                        state     <= RUN;
                        ch_idx_p0 <= '0;
                        BUSY      <= 1'b1;
                    end
                end
                RUN: begin
                    if (ch_idx_p0 == CH_W'(NUM_CH - 1)) begin
                        state <= LAST;
                    end else begin
                        ch_idx_p0 <= ch_idx_p0 + CH_W'(1);
                    end
                end
                LAST: begin
                    state <= PUBLISH;
                    VALID <= 1'b1;
                    for (int k = 0; k < NUM_CH; k++) begin
                        LUT_VALUE[k*BIT_WIDTH +: BIT_WIDTH] <= shadow_nxt[k];
                    end
                    LUT_END <= shadow_end;
                end
                PUBLISH: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_waveform_lut_dds_mc.sv
module tb_waveform_lut_dds_mc;

    localparam int NUM_CH = 4;
    localparam int BW     = 12;
    localparam int DEPTH  = 256;
    localparam int FRAC   = 8;
    localparam int AW     = 8;
    localparam int PW     = 16;
    localparam int PMOD   = 1 << PW;

    logic                   CLK_SYS = 1'b0;
    logic                   nRST;
    logic                   SMP_TRGG;
    logic [NUM_CH-1:0]      CH_EN;
    logic [NUM_CH-1:0]      CH_ONESHOT;
    logic [NUM_CH*PW-1:0]   CH_STEP;
    logic                   WR_EN;
    logic [AW-1:0]          WR_ADDR;
    logic [BW-1:0]          WR_DATA;
    logic                   CLR_OVR;
    logic [NUM_CH*BW-1:0]   LUT_VALUE;
    logic                   VALID;
    logic [NUM_CH-1:0]      LUT_END;
    logic                   BUSY;
    logic                   OVERRUN;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    logic [BW-1:0] m_ram [DEPTH];
    int unsigned   m_phase [NUM_CH];
    bit            m_done  [NUM_CH];

    waveform_lut_dds_mc #(
        .NUM_CH     (NUM_CH),
        .BIT_WIDTH  (BW),
        .LUT_DEPTH  (DEPTH),
        .FRAC_WIDTH (FRAC)
    ) dut (
        .CLK_SYS    (CLK_SYS),
        .nRST       (nRST),
        .SMP_TRGG   (SMP_TRGG),
        .CH_EN      (CH_EN),
        .CH_ONESHOT (CH_ONESHOT),
        .CH_STEP    (CH_STEP),
        .WR_EN      (WR_EN),
        .WR_ADDR    (WR_ADDR),
        .WR_DATA    (WR_DATA),
        .CLR_OVR    (CLR_OVR),
        .LUT_VALUE  (LUT_VALUE),
        .VALID      (VALID),
        .LUT_END    (LUT_END),
        .BUSY       (BUSY),
        .OVERRUN    (OVERRUN)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    function automatic logic [BW-1:0] ch_val(input int k);
        return LUT_VALUE[k*BW +: BW];
    endfunction

    // One sample trigger as the specification describes it, per channel.
    task automatic model_pass(output logic [NUM_CH*BW-1:0] ev, output logic [NUM_CH-1:0] ee);
        ev = '0;
        ee = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            int unsigned st;
            int unsigned nx;
            st = CH_STEP[k*PW +: PW];
            if (!CH_EN[k]) begin
                m_phase[k] = 0;
                m_done[k]  = 0;
            end else if (!m_done[k]) begin
                ev[k*BW +: BW] = m_ram[m_phase[k] >> FRAC];
                nx = m_phase[k] + st;
                if (nx >= PMOD) begin
                    ee[k] = 1'b1;
                    if (CH_ONESHOT[k]) begin
                        m_done[k]  = 1;
                        m_phase[k] = 0;
                    end else begin
                        m_phase[k] = nx - PMOD;
                    end
                end else begin
                    m_phase[k] = nx;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_phase[k] = 0;
            m_done[k]  = 0;
        end
    endtask

    task automatic ram_write(input int addr, input logic [BW-1:0] data);
        @(negedge CLK_SYS);
        WR_EN   = 1'b1;
        WR_ADDR = AW'(addr);
        WR_DATA = data;
        m_ram[addr] = data;
        @(negedge CLK_SYS);
        WR_EN = 1'b0;
    endtask

    task automatic trig_and_check(input string tag);
        logic [NUM_CH*BW-1:0] ev;
        logic [NUM_CH-1:0]    ee;
        int lat;
        @(negedge CLK_SYS);
        SMP_TRGG = 1'b1;
        model_pass(ev, ee);
        lat = 0;
        do begin
            @(negedge CLK_SYS);
            SMP_TRGG = 1'b0;
            lat++;
        end while (!VALID && lat < 20);
        n_total++;
        if (lat != NUM_CH + 2)
            $display("FAIL %s valid_latency got %0d want %0d", tag, lat, NUM_CH + 2);
        else n_pass++;
        n_total++;
        if (LUT_VALUE !== ev)
            $display("FAIL %s lut_value got %h want %h", tag, LUT_VALUE, ev);
        else n_pass++;
        n_total++;
        if (LUT_END !== ee)
            $display("FAIL %s lut_end got %b want %b", tag, LUT_END, ee);
        else n_pass++;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (3) @(negedge CLK_SYS);
        n_total++; if (LUT_VALUE !== '0) $display("FAIL rst_lut_value got %h want 0", LUT_VALUE); else n_pass++;
        n_total++; if (LUT_END !== '0)   $display("FAIL rst_lut_end got %b want 0", LUT_END);     else n_pass++;
        n_total++; if (VALID !== 1'b0)   $display("FAIL rst_valid got %b want 0", VALID);         else n_pass++;
        n_total++; if (BUSY !== 1'b0)    $display("FAIL rst_busy got %b want 0", BUSY);           else n_pass++;
        n_total++; if (OVERRUN !== 1'b0) $display("FAIL rst_overrun got %b want 0", OVERRUN);     else n_pass++;
        nRST = 1'b1;
        model_reset();
        @(negedge CLK_SYS);
    endtask

    task automatic test_ramp_fractional();
        for (int i = 0; i < DEPTH; i++) ram_write(i, BW'(i));
        CH_EN      = '1;
        CH_ONESHOT = 4'b1000;
        CH_STEP    = {16'h4000, 16'h0180, 16'h0080, 16'h0100};
        for (int n = 1; n <= 257; n++) begin
            trig_and_check("ramp");
            n_total++;
            if (ch_val(0) !== BW'((n - 1) % 256))
                $display("FAIL ramp_ch0 n=%0d got %h want %h", n, ch_val(0), BW'((n - 1) % 256));
            else n_pass++;
            if (n == 4) begin
                n_total++; if (ch_val(2) !== BW'(4))   $display("FAIL frac_ch2 got %h want 004", ch_val(2)); else n_pass++;
                n_total++; if (ch_val(3) !== BW'(192)) $display("FAIL oneshot_last got %h want 0c0", ch_val(3)); else n_pass++;
                n_total++; if (LUT_END[3] !== 1'b1)    $display("FAIL oneshot_end got %b want 1", LUT_END[3]); else n_pass++;
            end
            if (n == 5) begin
                n_total++; if (ch_val(1) !== BW'(2)) $display("FAIL frac_ch1 got %h want 002", ch_val(1)); else n_pass++;
                n_total++; if (ch_val(3) !== BW'(0)) $display("FAIL oneshot_done got %h want 000", ch_val(3)); else n_pass++;
            end
            if (n == 256 || n == 257) begin
                n_total++;
                if (LUT_END[0] !== (n == 256))
                    $display("FAIL ramp_end0 n=%0d got %b want %b", n, LUT_END[0], (n == 256));
                else n_pass++;
            end
        end
    endtask

    task automatic test_oneshot_rearm();
        CH_EN[3] = 1'b0;
        trig_and_check("rearm_off");
        n_total++; if (ch_val(3) !== BW'(0)) $display("FAIL rearm_off_ch3 got %h want 000", ch_val(3)); else n_pass++;
        CH_EN[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            trig_and_check("rearm");
            n_total++;
            if (ch_val(3) !== ((i < 4) ? BW'(i * 64) : BW'(0)))
                $display("FAIL rearm_ch3 i=%0d got %h want %h", i, ch_val(3), (i < 4) ? BW'(i * 64) : BW'(0));
            else n_pass++;
            n_total++;
            if (LUT_END[3] !== (i == 3))
                $display("FAIL rearm_end3 i=%0d got %b want %b", i, LUT_END[3], (i == 3));
            else n_pass++;
        end
    endtask

    task automatic test_overrun();
        logic [NUM_CH*BW-1:0] ev;
        logic [NUM_CH-1:0]    ee;
        int lat;
        @(negedge CLK_SYS); SMP_TRGG = 1'b1; model_pass(ev, ee);
        @(negedge CLK_SYS); SMP_TRGG = 1'b0;
        n_total++; if (BUSY !== 1'b1) $display("FAIL ovr_busy got %b want 1", BUSY); else n_pass++;
        @(negedge CLK_SYS);
        @(negedge CLK_SYS); SMP_TRGG = 1'b1;
        @(negedge CLK_SYS); SMP_TRGG = 1'b0;
        n_total++; if (OVERRUN !== 1'b1) $display("FAIL ovr_set got %b want 1", OVERRUN); else n_pass++;
        lat = 4;
        while (!VALID && lat < 20) begin @(negedge CLK_SYS); lat++; end
        n_total++; if (lat != NUM_CH + 2) $display("FAIL ovr_latency got %0d want %0d", lat, NUM_CH + 2); else n_pass++;
        n_total++; if (LUT_VALUE !== ev) $display("FAIL ovr_value got %h want %h", LUT_VALUE, ev); else n_pass++;
        n_total++; if (LUT_END !== ee)   $display("FAIL ovr_end got %b want %b", LUT_END, ee); else n_pass++;
        @(negedge CLK_SYS);
        n_total++; if (VALID !== 1'b0)   $display("FAIL valid_pulse got %b want 0", VALID); else n_pass++;
        n_total++; if (BUSY !== 1'b0)    $display("FAIL busy_end got %b want 0", BUSY); else n_pass++;
        n_total++; if (OVERRUN !== 1'b1) $display("FAIL ovr_sticky got %b want 1", OVERRUN); else n_pass++;
        CLR_OVR = 1'b1;
        @(negedge CLK_SYS); CLR_OVR = 1'b0;
        n_total++; if (OVERRUN !== 1'b0) $display("FAIL ovr_clear got %b want 0", OVERRUN); else n_pass++;
        // set and clear together
        @(negedge CLK_SYS); SMP_TRGG = 1'b1; model_pass(ev, ee);
        @(negedge CLK_SYS); SMP_TRGG = 1'b0;
        @(negedge CLK_SYS); SMP_TRGG = 1'b1; CLR_OVR = 1'b1;
        @(negedge CLK_SYS); SMP_TRGG = 1'b0; CLR_OVR = 1'b0;
        n_total++; if (OVERRUN !== 1'b1) $display("FAIL ovr_set_wins got %b want 1", OVERRUN); else n_pass++;
        lat = 3;
        while (!VALID && lat < 20) begin @(negedge CLK_SYS); lat++; end
        n_total++; if (LUT_VALUE !== ev) $display("FAIL ovr2_value got %h want %h", LUT_VALUE, ev); else n_pass++;
        @(negedge CLK_SYS); CLR_OVR = 1'b1;
        @(negedge CLK_SYS); CLR_OVR = 1'b0;
        // minimum trigger spacing is accepted
        trig_and_check("b2b_a");
        trig_and_check("b2b_b");
        n_total++; if (OVERRUN !== 1'b0) $display("FAIL b2b_overrun got %b want 0", OVERRUN); else n_pass++;
    endtask

    task automatic test_write_during_run();
        logic [NUM_CH*BW-1:0] ev;
        logic [NUM_CH-1:0]    ee;
        logic [BW-1:0]        old;
        int addr;
        int lat;
        CH_EN = 4'b0001;
        CH_STEP[0 +: PW] = '0;
        addr = int'(m_phase[0] >> FRAC);
        old  = m_ram[addr];
        @(negedge CLK_SYS); SMP_TRGG = 1'b1; model_pass(ev, ee);
        @(negedge CLK_SYS); SMP_TRGG = 1'b0;
        WR_EN = 1'b1; WR_ADDR = AW'(addr); WR_DATA = 12'h7FF;
        @(negedge CLK_SYS); WR_EN = 1'b0;
        m_ram[addr] = 12'h7FF;
        lat = 2;
        while (!VALID && lat < 20) begin @(negedge CLK_SYS); lat++; end
        n_total++; if (lat != NUM_CH + 2) $display("FAIL wr_latency got %0d want %0d", lat, NUM_CH + 2); else n_pass++;
        n_total++; if (LUT_VALUE !== ev) $display("FAIL wr_value got %h want %h", LUT_VALUE, ev); else n_pass++;
        n_total++; if (ch_val(0) !== old) $display("FAIL wr_old got %h want %h", ch_val(0), old); else n_pass++;
        trig_and_check("wr_next");
        n_total++; if (ch_val(0) !== 12'h7FF) $display("FAIL wr_new got %h want 7ff", ch_val(0)); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        bit saw_valid;
        CH_EN   = '1;
        CH_STEP = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
        trig_and_check("pre_rst");
        @(negedge CLK_SYS); SMP_TRGG = 1'b1;
        @(negedge CLK_SYS); SMP_TRGG = 1'b0;
        @(negedge CLK_SYS); nRST = 1'b0;
        @(negedge CLK_SYS);
        n_total++; if (BUSY !== 1'b0)    $display("FAIL mid_rst_busy got %b want 0", BUSY); else n_pass++;
        n_total++; if (VALID !== 1'b0)   $display("FAIL mid_rst_valid got %b want 0", VALID); else n_pass++;
        n_total++; if (LUT_VALUE !== '0) $display("FAIL mid_rst_value got %h want 0", LUT_VALUE); else n_pass++;
        n_total++; if (LUT_END !== '0)   $display("FAIL mid_rst_end got %b want 0", LUT_END); else n_pass++;
        nRST = 1'b1;
        model_reset();
        saw_valid = 1'b0;
        repeat (NUM_CH + 4) begin
            @(negedge CLK_SYS);
            if (VALID) saw_valid = 1'b1;
        end
        n_total++; if (saw_valid) $display("FAIL mid_rst_no_valid got 1 want 0"); else n_pass++;
        trig_and_check("post_rst");
        n_total++; if (ch_val(0) !== m_ram[0]) $display("FAIL post_rst_ch0 got %h want %h", ch_val(0), m_ram[0]); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int w = 0; w < 3; w++) ram_write($urandom_range(0, DEPTH - 1), BW'($urandom));
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if ($urandom_range(0, 3) == 0)
                    CH_STEP[k*PW +: PW] = ($urandom_range(0, 1) == 1) ? PW'($urandom) : PW'($urandom_range(0, 16'h0800));
                CH_EN[k] = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 7) == 0) CH_ONESHOT[k] = ~CH_ONESHOT[k];
            end
            repeat ($urandom_range(0, 3)) @(negedge CLK_SYS);
            trig_and_check("random");
        end
    endtask

    initial begin
        nRST       = 1'b0;
        SMP_TRGG   = 1'b0;
        CH_EN      = '0;
        CH_ONESHOT = '0;
        CH_STEP    = '0;
        WR_EN      = 1'b0;
        WR_ADDR    = '0;
        WR_DATA    = '0;
        CLR_OVR    = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_ram[i] = '0;
        model_reset();
        test_reset();
        test_ramp_fractional();
        test_oneshot_rearm();
        test_overrun();
        test_write_during_run();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
